// File: rtl/debug_ring_sequencer.sv
// Autonomous debug-ring scan sequencer: optional ring load, then NUM_WORDS x 32 shifted bits, TX buffer out / RX buffer in.
// Optional build macro DEBUG_SEQ_LOOPBACK_EN adds a loopback input that feeds the RX path from debug_do internally.
module debug_ring_sequencer #(
    parameter int NUM_WORDS   = 4,
    parameter int CMD_LATENCY = 2
) (
    input  logic        mclk,
    input  logic        mrst_n,
    input  logic        start,
    input  logic        load_first,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        debug_do,
    output logic        debug_sl,
    input  logic        debug_di
`ifdef DEBUG_SEQ_LOOPBACK_EN
    ,
    input  logic        loopback
`endif
);

    localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BW = AW + 5;
    localparam int PW = CMD_LATENCY + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(32 * NUM_WORDS - 1);
    localparam logic [4:0] WORDS = 5'(NUM_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        SHIFT,
        DRAIN
    } state_t;

    state_t state;

    logic [31:0]   tx_mem [NUM_WORDS];
    logic [31:0]   rx_mem [NUM_WORDS];

    logic          load_cnt;
    logic          phase;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_nxt;
    logic [BW-1:0] rx_cnt;
    logic [31:0]   rx_shift;
    logic          rx_we;
    logic [AW-1:0] rx_widx;
    logic [PW-1:0] stb_pipe;
    logic          strobe;
    logic          sample;
    logic          last_sample;
    logic          kill;
    logic          ring_in;
    logic          tx_next_bit;
    logic          wr_ok;
    logic          rd_ok;

`ifdef DEBUG_SEQ_LOOPBACK_EN
    logic [PW-1:0] do_pipe;
`endif

    always_comb begin
        strobe      = (state == SHIFT) && !phase;
        sample      = stb_pipe[PW-1];
        last_sample = sample && (rx_cnt == LAST_BIT);
        kill        = abort && (state != IDLE);
        bit_nxt     = bit_cnt + BW'(1);
        tx_next_bit = tx_mem[bit_nxt[BW-1:5]][bit_nxt[4:0]];
        wr_ok       = wr_en && (state == IDLE) && ({1'b0, wr_addr} < WORDS);
        rd_ok       = {1'b0, rd_addr} < WORDS;
`ifdef DEBUG_SEQ_LOOPBACK_EN
        ring_in     = loopback ? do_pipe[PW-1] : debug_di;
`else
        ring_in     = debug_di;
`endif
    end

    // Buffers carry no reset; their contents are undefined until written.
    always_ff @(posedge mclk) begin
        if (wr_ok) begin
            tx_mem[wr_addr[AW-1:0]] <= wr_data;
        end
        if (rx_we && !kill) begin
            rx_mem[rx_widx] <= rx_shift;
        end
    end

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            debug_sl <= 1'b0;
            debug_do <= 1'b0;
            rd_data  <= '0;
            load_cnt <= 1'b0;
            phase    <= 1'b0;
            bit_cnt  <= '0;
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_we    <= 1'b0;
            rx_widx  <= '0;
            stb_pipe <= '0;
`ifdef DEBUG_SEQ_LOOPBACK_EN
            do_pipe  <= '0;
`endif
        end else begin
            done     <= 1'b0;
            rx_we    <= 1'b0;
            rd_data  <= rd_ok ? rx_mem[rd_addr[AW-1:0]] : '0;
            // Delayed copy of the shift strobe lines up with the ring's return latency.
            stb_pipe <= PW'({stb_pipe, strobe});
`ifdef DEBUG_SEQ_LOOPBACK_EN
            do_pipe  <= PW'({do_pipe, debug_do});
`endif

            if (sample) begin
                rx_shift <= {ring_in, rx_shift[31:1]};
                rx_cnt   <= rx_cnt + BW'(1);
                if (rx_cnt[4:0] == 5'd31) begin
                    rx_we   <= 1'b1;
                    rx_widx <= rx_cnt[BW-1:5];
                end
            end

            if (kill) begin
                state    <= IDLE;
                busy     <= 1'b0;
                debug_sl <= 1'b0;
                debug_do <= 1'b0;
                rx_we    <= 1'b0;
                phase    <= 1'b0;
                stb_pipe <= '0;
`ifdef DEBUG_SEQ_LOOPBACK_EN
                do_pipe  <= '0;
`endif
            end else if (last_sample) begin
                // With zero latency the final sample lands in SHIFT, so this overrides any state.
                state    <= IDLE;
                busy     <= 1'b0;
                done     <= 1'b1;
                debug_sl <= 1'b0;
                debug_do <= 1'b0;
                phase    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            busy     <= 1'b1;
                            bit_cnt  <= '0;
                            rx_cnt   <= '0;
                            phase    <= 1'b0;
                            load_cnt <= 1'b0;
                            debug_sl <= 1'b1;
                            if (load_first) begin
                                state    <= LOAD;
                                debug_do <= 1'b0;
                            end else begin
                                state    <= SHIFT;
                                debug_do <= tx_mem[0][0];
                            end
                        end
                    end
                    LOAD: begin
                        if (load_cnt) begin
                            state    <= GAP;
                            debug_sl <= 1'b0;
                        end else begin
                            load_cnt <= 1'b1;
                        end
                    end
                    GAP: begin
                        state    <= SHIFT;
                        phase    <= 1'b0;
                        debug_sl <= 1'b1;
                        debug_do <= tx_mem[0][0];
                    end
                    SHIFT: begin
                        if (!phase) begin
                            phase    <= 1'b1;
                            debug_sl <= 1'b0;
                        end else if (bit_cnt == LAST_BIT) begin
                            state    <= DRAIN;
                            phase    <= 1'b0;
                            debug_do <= 1'b0;
                        end else begin
                            bit_cnt  <= bit_nxt;
                            phase    <= 1'b0;
                            debug_sl <= 1'b1;
                            debug_do <= tx_next_bit;
                        end
                    end
                    DRAIN: begin
                        debug_sl <= 1'b0;
                        debug_do <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debug_ring_sequencer.sv
// Directed bench for debug_ring_sequencer with a 128-bit ring model behind a CMD_LATENCY command pipe.
module tb_debug_ring_sequencer;

    localparam int NW = 4;
    localparam int CL = 2;
    localparam logic [127:0] IMAGE = 128'h0123456789ABCDEF_FEDCBA9876543210;

    logic        mclk = 1'b0;
    logic        mrst_n = 1'b0;
    logic        start = 1'b0;
    logic        load_first = 1'b0;
    logic        abort = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  rd_addr = '0;
    logic        busy;
    logic        done;
    logic [31:0] rd_data;
    logic        debug_do;
    logic        debug_sl;
    logic        debug_di = 1'b0;
`ifdef DEBUG_SEQ_LOOPBACK_EN
    logic        loopback = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] pat [NW] = '{32'h0000FFFF, 32'hA5A5A5A5, 32'h9ABCDEF0, 32'h12345678};
    logic [31:0] img_w [NW] = '{32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567};

    int          done_cyc;
    int          n_done;
    int          busy_fall;
    logic [4:0]  sl_early;
    logic        busy1;
    logic [31:0] rd_post1;
    logic [31:0] rd_post2;

    always #5 mclk = ~mclk;

    debug_ring_sequencer #(.NUM_WORDS(NW), .CMD_LATENCY(CL)) dut (
        .mclk       (mclk),
        .mrst_n     (mrst_n),
        .start      (start),
        .load_first (load_first),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .debug_do   (debug_do),
        .debug_sl   (debug_sl),
        .debug_di   (debug_di)
`ifdef DEBUG_SEQ_LOOPBACK_EN
        ,
        .loopback   (loopback)
`endif
    );

    // Ring model: hsl[k]/hdo[k] hold the pins k cycles ago; the ring acts CL cycles late.
    logic [CL+2:0] hsl = '0;
    logic [CL+2:0] hdo = '0;
    logic [127:0]  ring = '0;
    always @(negedge mclk) begin
        hsl = {hsl[CL+1:0], debug_sl};
        hdo = {hdo[CL+1:0], debug_do};
        debug_di = ring[0];
        if (hsl[CL+1] && !hsl[CL+2]) begin
            if (hsl[CL]) ring = IMAGE;
            else         ring = {hdo[CL+1], ring[127:1]};
        end
    end

    task automatic write_tx(input logic [3:0] a, input logic [31:0] d);
        @(posedge mclk); #1;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge mclk); #1;
        wr_en = 1'b0;
    endtask

    task automatic read_rx(input logic [3:0] a, output logic [31:0] d);
        @(posedge mclk); #1;
        rd_addr = a;
        @(posedge mclk); #1;
        d = rd_data;
    endtask

    // Cycle 0 is the cycle start is high; observations are taken 1 time unit after each edge.
    task automatic run_scan(input logic lf, input int restart_at, input int wr_at);
        @(posedge mclk); #1;
        start = 1'b1; load_first = lf;
        done_cyc = -1; n_done = 0; busy_fall = -1; sl_early = '0; busy1 = 1'b0;
        rd_post1 = '0; rd_post2 = '0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge mclk); #1;
            start = 1'b0; wr_en = 1'b0;
            if (c <= 4) sl_early = {debug_sl, sl_early[4:1]};
            if (c == 1) busy1 = busy;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc > 0 && c == done_cyc + 1) rd_post1 = rd_data;
            if (done_cyc > 0 && c == done_cyc + 2) rd_post2 = rd_data;
            if (!busy && busy_fall < 0) busy_fall = c;
            if (c == restart_at) begin start = 1'b1; load_first = ~lf; end
            if (c == wr_at) begin wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h0; end
            if (busy_fall > 0 && c >= busy_fall + 4) break;
        end
        start = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge mclk);
        #1;
        checks++;
        if ({busy, done, debug_sl, debug_do, rd_data} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b sl=%b do=%b rd=%h want all 0",
                     busy, done, debug_sl, debug_do, rd_data);
        end
        mrst_n = 1'b1;
    endtask

    task automatic test_load_scan();
        logic [31:0] d;
        for (int k = 0; k < NW; k++) write_tx(4'(k), 32'hFFFFFFFF);
        run_scan(1'b1, -1, -1);
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL load_busy_c1: got %b want 1", busy1); end
        checks++;
        if (sl_early !== 5'b10110) begin errors++; $display("FAIL load_sl_c1_4: got %b want 10110", sl_early); end
        checks++;
        if (done_cyc !== 262) begin errors++; $display("FAIL load_done_cycle: got %0d want 262", done_cyc); end
        checks++;
        if (busy_fall !== 262) begin errors++; $display("FAIL load_busy_fall: got %0d want 262", busy_fall); end
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL load_done_count: got %0d want 1", n_done); end
        for (int k = 0; k < NW; k++) begin
            read_rx(4'(k), d);
            checks++;
            if (d !== img_w[k]) begin errors++; $display("FAIL load_rx%0d: got %h want %h", k, d, img_w[k]); end
        end
    endtask

    task automatic test_shift_only();
        logic [31:0] d;
        for (int k = 0; k < NW; k++) write_tx(4'(k), pat[k]);
        run_scan(1'b0, -1, -1);
        checks++;
        if (sl_early !== 5'b01010) begin errors++; $display("FAIL shift_sl_c1_4: got %b want 01010", sl_early); end
        checks++;
        if (done_cyc !== 259) begin errors++; $display("FAIL shift_done_cycle: got %0d want 259", done_cyc); end
        for (int k = 0; k < NW; k++) begin
            read_rx(4'(k), d);
            checks++;
            if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL shift_rx%0d: got %h want ffffffff", k, d); end
        end
    endtask

    task automatic test_ring_order();
        logic [31:0] d;
        for (int k = 0; k < NW; k++) write_tx(4'(k), 32'hFFFFFFFF);
        run_scan(1'b0, -1, -1);
        for (int k = 0; k < NW; k++) begin
            read_rx(4'(k), d);
            checks++;
            if (d !== pat[k]) begin errors++; $display("FAIL order_rx%0d: got %h want %h", k, d, pat[k]); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        logic [31:0] exp_w [NW];
        int saw_done;
        exp_w = '{img_w[0], img_w[1], pat[2], pat[3]};
        saw_done = 0;
        @(posedge mclk); #1;
        start = 1'b1; load_first = 1'b1;
        for (int c = 1; c <= 151; c++) begin
            @(posedge mclk); #1;
            start = 1'b0; abort = 1'b0;
            if (done) saw_done++;
            if (c == 150) abort = 1'b1;
        end
        checks++;
        if ({busy, debug_sl, debug_do} !== 3'b000) begin
            errors++;
            $display("FAIL abort_c151: got busy=%b sl=%b do=%b want 000", busy, debug_sl, debug_do);
        end
        @(posedge mclk); #1;
        if (done) saw_done++;
        start = 1'b1; load_first = 1'b0;
        @(posedge mclk); #1;
        start = 1'b0;
        if (done) saw_done++;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_restart_c153: busy got %b want 1", busy); end
        checks++;
        if (saw_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", saw_done); end
        for (int k = 0; k < NW; k++) begin
            read_rx(4'(k), d);
            checks++;
            if (d !== exp_w[k]) begin errors++; $display("FAIL abort_rx%0d: got %h want %h", k, d, exp_w[k]); end
        end
        @(posedge mclk); #1;
        abort = 1'b1;
        @(posedge mclk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_second: busy got %b want 0", busy); end
    endtask

    task automatic test_start_abort_same();
        @(posedge mclk); #1;
        start = 1'b1; abort = 1'b1; load_first = 1'b1;
        @(posedge mclk); #1;
        start = 1'b0; abort = 1'b0;
        checks++;
        if ({busy, debug_sl} !== 2'b00) begin
            errors++;
            $display("FAIL start_abort_same: got busy=%b sl=%b want 00", busy, debug_sl);
        end
        repeat (4) @(posedge mclk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_later: busy got %b want 0", busy); end
    endtask

    task automatic test_busy_inputs();
        logic [31:0] d;
        write_tx(4'd5, 32'h0);
        read_rx(4'd9, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rd_out_of_range: got %h want 0", d); end
        run_scan(1'b1, 50, 60);
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", n_done); end
        checks++;
        if (done_cyc !== 262) begin errors++; $display("FAIL busy_done_cycle: got %0d want 262", done_cyc); end
        read_rx(4'd3, d);
        checks++;
        if (d !== img_w[3]) begin errors++; $display("FAIL busy_rx3: got %h want %h", d, img_w[3]); end
    endtask

    task automatic test_read_collision();
        logic [31:0] d;
        @(posedge mclk); #1;
        rd_addr = 4'd3;
        run_scan(1'b0, -1, -1);
        checks++;
        if (rd_post1 !== 32'h01234567) begin errors++; $display("FAIL collide_old: got %h want 01234567", rd_post1); end
        checks++;
        if (rd_post2 !== 32'hFFFFFFFF) begin errors++; $display("FAIL collide_new: got %h want ffffffff", rd_post2); end
        for (int k = 0; k < NW; k++) begin
            read_rx(4'(k), d);
            checks++;
            if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL tx_kept_rx%0d: got %h want ffffffff", k, d); end
        end
    endtask

`ifdef DEBUG_SEQ_LOOPBACK_EN
    task automatic test_loopback();
        logic [31:0] d;
        logic [31:0] lb [NW];
        lb = '{32'h0000FFFF, 32'hA5A5A5A5, 32'h9ABCDEF0, 32'h12345678};
        for (int k = 0; k < NW; k++) write_tx(4'(k), lb[k]);
        loopback = 1'b1;
        run_scan(1'b1, -1, -1);
        loopback = 1'b0;
        for (int k = 0; k < NW; k++) begin
            read_rx(4'(k), d);
            checks++;
            if (d !== lb[k]) begin errors++; $display("FAIL loopback_rx%0d: got %h want %h", k, d, lb[k]); end
        end
    endtask
`endif

    task automatic test_midscan_reset();
        @(posedge mclk); #1;
        start = 1'b1; load_first = 1'b1;
        @(posedge mclk); #1;
        start = 1'b0;
        repeat (19) @(posedge mclk);
        #1;
        mrst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, debug_sl, debug_do, rd_data} !== 36'h0) begin
            errors++;
            $display("FAIL midscan_reset: got busy=%b done=%b sl=%b do=%b rd=%h want all 0",
                     busy, done, debug_sl, debug_do, rd_data);
        end
        @(posedge mclk); #1;
        mrst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_scan();
        test_shift_only();
        test_ring_order();
        test_abort();
        test_start_abort_same();
        test_busy_inputs();
        test_read_collision();
`ifdef DEBUG_SEQ_LOOPBACK_EN
        test_loopback();
`endif
        test_midscan_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
